// File: rtl/nav_pkg.sv
// Shared navigation definitions: motor command encoding, controller states and
// obstacle-detector bit positions. The fork detector stage imports this too.
package nav_pkg;

    localparam logic [1:0] MOVE_STOP  = 2'd0;
    localparam logic [1:0] MOVE_FWD   = 2'd1;
    localparam logic [1:0] MOVE_LEFT  = 2'd2;
    localparam logic [1:0] MOVE_RIGHT = 2'd3;

    localparam int DET_FRONT = 3;
    localparam int DET_BACK  = 2;
    localparam int DET_LEFT  = 1;
    localparam int DET_RIGHT = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRUISE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_TURN   = 3'd4,
        ST_EXIT   = 3'd5
    } nav_state_e;

    // Debug view: current state, latched turn direction, detector snapshot from the last DECIDE.
    typedef struct packed {
        nav_state_e state;
        logic [1:0] dir;
        logic [3:0] det_snap;
    } nav_dbg_t;

    // Dead end: front, left and right all blocked; the back bit plays no part.
    function automatic logic is_dead_end(input logic [3:0] det);
        return det[DET_FRONT] & det[DET_LEFT] & det[DET_RIGHT];
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that times the SETTLE, TURN and EXIT phases.
// Holds at zero instead of wrapping; clear beats load beats decrement.
module cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/fork_nav_fsm.sv
// Junction navigation controller: stops at a fork or dead end, picks an exit
// with a left-hand-wall rule, times the turn and drives clear before cruising.
module fork_nav_fsm
    import nav_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int TURN_CYC   = 10,
    parameter int UTURN_CYC  = 20,
    parameter int EXIT_CYC   = 6,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_en,
    input  logic       detect_fork,
    input  logic [3:0] detector_signal,
    output logic [1:0] move_cmd,
    output logic       busy,
    output logic [7:0] fork_cnt,
    output nav_dbg_t   dbg
);

    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_TURN   = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_UTURN  = CNT_W'(UTURN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXIT   = CNT_W'(EXIT_CYC - 1);

    nav_state_e       r_state;
    logic [1:0]       r_dir;
    logic [1:0]       r_move_cmd;
    logic             r_busy;
    logic [7:0]       r_fork_cnt;
    logic [3:0]       r_det_snap;

    nav_state_e       w_state_nxt;
    logic [1:0]       w_dir_nxt;
    logic [1:0]       w_move_nxt;
    logic             w_busy_nxt;
    logic             w_cnt_inc;
    logic             w_tmr_clr;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_done;

    cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_tmr_clr),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    // Dropping auto_en overrides everything, including a DECIDE about to count.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_inc   = 1'b0;
        w_tmr_clr   = ~auto_en;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        if (!auto_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CRUISE;
                ST_CRUISE: begin
                    if (detect_fork || is_dead_end(detector_signal)) begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = LD_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_done) w_state_nxt = ST_DECIDE;
                end
                ST_DECIDE: begin
                    w_cnt_inc  = 1'b1;
                    w_tmr_load = 1'b1;
                    if (!detector_signal[DET_LEFT]) begin
                        w_dir_nxt   = MOVE_LEFT;
                        w_state_nxt = ST_TURN;
                        w_tmr_val   = LD_TURN;
                    end else if (!detector_signal[DET_FRONT]) begin
                        w_state_nxt = ST_EXIT;
                        w_tmr_val   = LD_EXIT;
                    end else if (!detector_signal[DET_RIGHT]) begin
                        w_dir_nxt   = MOVE_RIGHT;
                        w_state_nxt = ST_TURN;
                        w_tmr_val   = LD_TURN;
                    end else begin
                        w_dir_nxt   = MOVE_RIGHT;
                        w_state_nxt = ST_TURN;
                        w_tmr_val   = LD_UTURN;
                    end
                end
                ST_TURN: begin
                    if (w_tmr_done) begin
                        w_state_nxt = ST_EXIT;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = LD_EXIT;
                    end
                end
                ST_EXIT: begin
                    if (w_tmr_done) w_state_nxt = ST_CRUISE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decode from the next state so they register on the same edge as the state.
    always_comb begin
        w_move_nxt = MOVE_STOP;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            ST_CRUISE: w_move_nxt = MOVE_FWD;
            ST_SETTLE, ST_DECIDE: w_busy_nxt = 1'b1;
            ST_TURN: begin
                w_move_nxt = w_dir_nxt;
                w_busy_nxt = 1'b1;
            end
            ST_EXIT: begin
                w_move_nxt = MOVE_FWD;
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_move_nxt = MOVE_STOP;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dir      <= MOVE_LEFT;
            r_move_cmd <= MOVE_STOP;
            r_busy     <= 1'b0;
            r_fork_cnt <= 8'd0;
            r_det_snap <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_move_cmd <= w_move_nxt;
            r_busy     <= w_busy_nxt;
            if (w_cnt_inc) begin
                r_fork_cnt <= r_fork_cnt + 8'd1;
                r_det_snap <= detector_signal;
            end
        end
    end

    assign move_cmd = r_move_cmd;
    assign busy     = r_busy;
    assign fork_cnt = r_fork_cnt;

    always_comb begin
        dbg          = '0;
        dbg.state    = r_state;
        dbg.dir      = r_dir;
        dbg.det_snap = r_det_snap;
    end

endmodule

// File: tb/tb_fork_nav_fsm.sv
// Directed bench for fork_nav_fsm: the driver queues the expected
// {move_cmd, busy, fork_cnt} for every edge, a monitor pops and compares.
module tb_fork_nav_fsm;
    import nav_pkg::*;

    localparam int S = 4;
    localparam int T = 10;
    localparam int U = 20;
    localparam int X = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       auto_en;
    logic       detect_fork;
    logic [3:0] det;
    logic [1:0] move_cmd;
    logic       busy;
    logic [7:0] fork_cnt;
    nav_dbg_t   dbg;

    logic [10:0] exp_q[$];
    logic [7:0]  exp_cnt = 8'd0;
    int          n_cmp = 0;
    int          n_err = 0;
    string       tag = "init";

    always #5 clk = ~clk;

    fork_nav_fsm #(
        .SETTLE_CYC (S),
        .TURN_CYC   (T),
        .UTURN_CYC  (U),
        .EXIT_CYC   (X),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .auto_en         (auto_en),
        .detect_fork     (detect_fork),
        .detector_signal (det),
        .move_cmd        (move_cmd),
        .busy            (busy),
        .fork_cnt        (fork_cnt),
        .dbg             (dbg)
    );

    // Queue the expected outputs for the coming edge, then advance to the next falling edge.
    task automatic step(input logic [1:0] m, input logic b);
        exp_q.push_back({m, b, exp_cnt});
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Junction from CRUISE: trig drives the CRUISE edge, dec is what DECIDE sees.
    task automatic junction(input logic fk, input logic [3:0] trig, input logic [3:0] dec,
                            input logic [1:0] tcmd, input int tlen);
        detect_fork = fk;
        det         = trig;
        step(MOVE_STOP, 1'b1);
        detect_fork = 1'b0;
        det         = dec;
        repeat (S) step(MOVE_STOP, 1'b1);
        exp_cnt++;
        if (tlen > 0) begin
            step(tcmd, 1'b1);
            det = 4'b0000;
            repeat (tlen - 1) step(tcmd, 1'b1);
            repeat (X) step(MOVE_FWD, 1'b1);
        end else begin
            step(MOVE_FWD, 1'b1);
            det = 4'b0000;
            repeat (X - 1) step(MOVE_FWD, 1'b1);
        end
        step(MOVE_FWD, 1'b0);
    endtask

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({move_cmd, busy, fork_cnt} !== e) begin
                    n_err++;
                    $display("FAIL %s @%0t: got cmd=%0d busy=%0b cnt=%0d, want cmd=%0d busy=%0b cnt=%0d",
                             tag, $time, move_cmd, busy, fork_cnt, e[10:9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst         = 1'b1;
        auto_en     = 1'b0;
        detect_fork = 1'b0;
        det         = 4'b0000;
        repeat (2) @(negedge clk);
        check_val("reset_move_cmd", 32'(move_cmd), 32'(MOVE_STOP));
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_fork_cnt", 32'(fork_cnt), 32'd0);
        check_val("reset_state", 32'(dbg.state), 32'(ST_IDLE));
        check_val("reset_dir", 32'(dbg.dir), 32'(MOVE_LEFT));
        rst = 1'b0;

        tag = "idle_hold";
        step(MOVE_STOP, 1'b0);
        step(MOVE_STOP, 1'b0);

        tag = "enable";
        auto_en = 1'b1;
        step(MOVE_FWD, 1'b0);

        tag = "cruise_no_junction";
        det = 4'b0100; step(MOVE_FWD, 1'b0);
        det = 4'b1010; step(MOVE_FWD, 1'b0);
        det = 4'b0011; step(MOVE_FWD, 1'b0);
        det = 4'b1110; step(MOVE_FWD, 1'b0);
        det = 4'b0000; step(MOVE_FWD, 1'b0);

        tag = "left_branch";
        junction(1'b1, 4'b1001, 4'b1001, MOVE_LEFT, T);
        tag = "front_branch";
        junction(1'b1, 4'b0000, 4'b0110, MOVE_FWD, 0);
        tag = "right_branch";
        junction(1'b1, 4'b0000, 4'b1010, MOVE_RIGHT, T);
        tag = "dead_end";
        junction(1'b0, 4'b1011, 4'b1011, MOVE_RIGHT, U);
        tag = "dead_end_back_blocked";
        junction(1'b0, 4'b1111, 4'b1111, MOVE_RIGHT, U);
        check_val("decide_snapshot", 32'(dbg.det_snap), 32'(4'b1111));

        tag = "abort_turn";
        detect_fork = 1'b1;
        step(MOVE_STOP, 1'b1);
        detect_fork = 1'b0;
        det = 4'b1001;
        repeat (S) step(MOVE_STOP, 1'b1);
        exp_cnt++;
        repeat (5) step(MOVE_LEFT, 1'b1);
        det = 4'b0000;
        auto_en = 1'b0;
        step(MOVE_STOP, 1'b0);
        step(MOVE_STOP, 1'b0);
        auto_en = 1'b1;
        step(MOVE_FWD, 1'b0);
        step(MOVE_FWD, 1'b0);

        tag = "abort_decide";
        detect_fork = 1'b1;
        step(MOVE_STOP, 1'b1);
        detect_fork = 1'b0;
        repeat (S) step(MOVE_STOP, 1'b1);
        auto_en = 1'b0;
        step(MOVE_STOP, 1'b0);
        auto_en = 1'b1;
        step(MOVE_FWD, 1'b0);

        tag = "fork_with_disable";
        detect_fork = 1'b1;
        auto_en = 1'b0;
        step(MOVE_STOP, 1'b0);
        detect_fork = 1'b0;
        auto_en = 1'b1;
        step(MOVE_FWD, 1'b0);
        step(MOVE_FWD, 1'b0);

        tag = "async_reset_exit";
        detect_fork = 1'b1;
        step(MOVE_STOP, 1'b1);
        detect_fork = 1'b0;
        det = 4'b0110;
        repeat (S) step(MOVE_STOP, 1'b1);
        exp_cnt++;
        step(MOVE_FWD, 1'b1);
        det = 4'b0000;
        repeat (2) step(MOVE_FWD, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_move_cmd", 32'(move_cmd), 32'(MOVE_STOP));
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_fork_cnt", 32'(fork_cnt), 32'd0);
        check_val("async_rst_state", 32'(dbg.state), 32'(ST_IDLE));
        #1 rst = 1'b0;
        exp_cnt = 8'd0;
        step(MOVE_FWD, 1'b0);

        tag = "counter_wrap";
        for (int i = 0; i < 256; i++) begin
            junction(1'b1, 4'b0000, 4'b0110, MOVE_FWD, 0);
        end
        check_val("wrap_fork_cnt", 32'(fork_cnt), 32'd0);

        @(negedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
